// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, requests words from instruction memory
// over req/ack, and buffers one returned word for decode behind a valid/ready handshake.
module fetch_sequencer #(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] out_pc,
   output logic [DATA_WIDTH-1:0] out_instr,
   input  logic                  out_ready,
   output logic [31:0]           fetch_count
);

   localparam int unsigned CNT_WIDTH = 32;
   localparam int unsigned PC_STEP   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      KILL  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] pc, pc_nxt;
   logic [ADDR_WIDTH-1:0] kill_pc, kill_pc_nxt;
   logic [ADDR_WIDTH-1:0] out_pc_nxt;
   logic [DATA_WIDTH-1:0] out_instr_nxt;
   logic                  out_valid_nxt;
   logic [CNT_WIDTH-1:0]  fetch_count_nxt;
   logic [ADDR_WIDTH-1:0] redirect_target;
   logic [ADDR_WIDTH-1:0] pc_inc;

   // Redirect targets are word aligned; the low two bits carry no meaning.
   assign redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   assign pc_inc          = pc + ADDR_WIDTH'(PC_STEP);

   // A request is outstanding in FETCH and KILL; the address is always the PC,
   // which never moves while a request is waiting for its ack.
   assign imem_req  = (state == FETCH) || (state == KILL);
   assign imem_addr = pc;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         kill_pc     <= '0;
         out_valid   <= 1'b0;
         out_pc      <= '0;
         out_instr   <= '0;
         fetch_count <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         kill_pc     <= kill_pc_nxt;
         out_valid   <= out_valid_nxt;
         out_pc      <= out_pc_nxt;
         out_instr   <= out_instr_nxt;
         fetch_count <= fetch_count_nxt;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      kill_pc_nxt     = kill_pc;
      out_valid_nxt   = out_valid;
      out_pc_nxt      = out_pc;
      out_instr_nxt   = out_instr;
      fetch_count_nxt = fetch_count;

      unique case (state)
         IDLE: begin
            state_nxt = FETCH;
            if (redirect_valid) begin
               pc_nxt = redirect_target;
            end
         end

         FETCH: begin
            if (imem_ack) begin
               if (redirect_valid) begin
                  // Returned word belongs to the old path: drop it, refetch at target.
                  pc_nxt = redirect_target;
               end else begin
                  out_instr_nxt = imem_rdata;
                  out_pc_nxt    = pc;
                  out_valid_nxt = 1'b1;
                  pc_nxt        = pc_inc;
                  state_nxt     = DRAIN;
               end
            end else if (redirect_valid) begin
               // The pending request cannot be withdrawn; remember where to go after it.
               kill_pc_nxt = redirect_target;
               state_nxt   = KILL;
            end
         end

         KILL: begin
            if (imem_ack) begin
               pc_nxt    = redirect_valid ? redirect_target : kill_pc;
               state_nxt = FETCH;
            end else if (redirect_valid) begin
               kill_pc_nxt = redirect_target;
            end
         end

         DRAIN: begin
            if (redirect_valid) begin
               // Redirect wins over a simultaneous handshake; the buffered word is discarded.
               out_valid_nxt = 1'b0;
               pc_nxt        = redirect_target;
               state_nxt     = FETCH;
            end else if (out_ready) begin
               out_valid_nxt   = 1'b0;
               fetch_count_nxt = fetch_count + CNT_WIDTH'(1);
               state_nxt       = FETCH;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized scoreboard bench for fetch_sequencer: a memory model with random latency,
// random redirects/back-pressure/resets, and an expected-delivery queue checked by a monitor.
module tb_fetch_sequencer;

   localparam int unsigned AW     = 32;
   localparam int unsigned DW     = 32;
   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam int          NCYC   = 6000;

   logic          clk = 1'b0;
   logic          rst;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [DW-1:0] imem_rdata;
   logic          out_valid;
   logic [AW-1:0] out_pc;
   logic [DW-1:0] out_instr;
   logic          out_ready;
   logic [31:0]   fetch_count;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];

   fetch_sequencer #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RESET_PC   (RST_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .out_ready      (out_ready),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   // Memory contents are a fixed scramble of the address.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
   endfunction

   function automatic logic [31:0] pick_target();
      int unsigned r;
      r = $urandom_range(0, 7);
      case (r)
         0:       return 32'hFFFF_FFF8;
         1:       return 32'hFFFF_FFFE;
         2:       return 32'h0000_2003;
         3:       return 32'h0000_0300;
         4:       return 32'h0000_0400;
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Driver: memory responder plus control stimulus, updated just after each rising edge.
   initial begin
      logic        pend;
      int unsigned wait_left;
      logic [31:0] lat_addr;
      pend           = 1'b0;
      wait_left      = 0;
      lat_addr       = '0;
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_ack       = 1'b0;
      imem_rdata     = '0;
      out_ready      = 1'b0;
      exp_q.push_back(RST_PC);

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk);
         #1;
         // rst and imem_ack still hold the values the DUT just sampled.
         if (rst || imem_ack) pend = 1'b0;
         if (imem_req) begin
            if (!pend) begin
               pend      = 1'b1;
               wait_left = $urandom_range(0, 3);
               lat_addr  = imem_addr;
            end else begin
               check("addr_hold", imem_addr, lat_addr);
            end
         end else if (pend) begin
            check("req_hold", 32'(imem_req), 32'd1);
            pend = 1'b0;
         end
         if (pend && wait_left == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = memf(lat_addr);
         end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            if (pend) wait_left--;
         end

         rst            = (cyc < 2) || ($urandom_range(0, 149) == 0);
         redirect_valid = !rst && ($urandom_range(0, 15) == 0);
         redirect_pc    = pick_target();
         out_ready      = ($urandom_range(0, 9) < 7);

         if (rst) begin
            exp_q.delete();
            exp_q.push_back(RST_PC);
         end else if (redirect_valid) begin
            exp_q.delete();
            exp_q.push_back({redirect_pc[31:2], 2'b00});
         end
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Monitor: compares deliveries against the expected stream and checks reset behaviour.
   logic        have_reset = 1'b0;
   logic        prev_rst   = 1'b0;
   logic        prev2_rst  = 1'b0;
   logic [31:0] exp_count  = '0;
   int unsigned idle_cycles = 0;

   always @(negedge clk) begin
      logic [31:0] e;
      if (have_reset) begin
         check("fetch_count", fetch_count, exp_count);
         if (prev_rst) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_imem_req", 32'(imem_req), 32'd0);
            check("rst_out_pc", out_pc, 32'd0);
            check("rst_out_instr", out_instr, 32'd0);
         end
         if (prev2_rst && !prev_rst) begin
            check("first_req", 32'(imem_req), 32'd1);
         end
         idle_cycles++;
         if (idle_cycles > 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL liveness: no delivery for %0d cycles at %0t", idle_cycles, $time);
            idle_cycles = 0;
         end

         if (!rst && !redirect_valid && out_valid && out_ready) begin
            idle_cycles = 0;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_delivery: pc 0x%08h with no expectation at %0t", out_pc, $time);
            end else begin
               e = exp_q.pop_front();
               check("out_pc", out_pc, e);
               check("out_instr", out_instr, memf(e));
               exp_q.push_back(e + 32'd4);
            end
            exp_count = exp_count + 32'd1;
         end
      end

      if (rst) begin
         exp_count   = '0;
         idle_cycles = 0;
         have_reset  = 1'b1;
      end
      prev2_rst = prev_rst;
      prev_rst  = rst;
   end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequencing controller for the instruction-fetch datapath. It owns the program counter, issues word requests to instruction memory over a req/ack handshake that tolerates multi-cycle memory latency, and holds each returned word in a one-entry output buffer presented to decode with a valid/ready handshake. Control-flow redirects from later stages flush any buffered or in-flight fetch.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of PC and memory address
- DATA_WIDTH, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset; bits [1:0] must be zero

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- redirect_valid  in  1  redirect request, one-cycle pulse or held
- redirect_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored, treated as 0
- imem_req  out  1  memory request
- imem_addr  out  ADDR_WIDTH  request address
- imem_ack  in  1  memory completion; imem_rdata valid in the same cycle
- imem_rdata  in  DATA_WIDTH  fetched word
- out_valid  out  1  buffer holds an instruction
- out_pc  out  ADDR_WIDTH  address of buffered instruction
- out_instr  out  DATA_WIDTH  buffered instruction
- out_ready  in  1  decode accepts buffered instruction
- fetch_count  out  32  number of instructions delivered to decode

## Operation
- States: IDLE, FETCH, KILL, DRAIN. imem_req = 1 in FETCH and KILL, else 0. imem_addr = pc register in every state.
- Reset, on a clock edge with rst=1: state=IDLE, pc=RESET_PC, out_valid=0, out_pc=0, out_instr=0, fetch_count=0, kill_pc=0.
- IDLE: moves to FETCH next cycle. With redirect_valid: pc<=redirect_pc aligned, then FETCH.
- FETCH, imem_ack=1, no redirect: out_instr<=imem_rdata, out_pc<=pc, out_valid<=1, pc<=pc+4, state<=DRAIN.
- FETCH, imem_ack=1 with redirect_valid: data dropped, pc<=redirect_pc, remain in FETCH, out_valid stays 0.
- FETCH, imem_ack=0 with redirect_valid: kill_pc<=redirect_pc, state<=KILL. imem_req and imem_addr stay unchanged because the transaction cannot be withdrawn.
- KILL, imem_ack=0: wait. A further redirect overwrites kill_pc, so the latest redirect wins.
- KILL, imem_ack=1: data dropped, pc<=kill_pc, state<=FETCH. If a redirect arrives in the same cycle, pc<=that redirect_pc instead.
- DRAIN, out_ready=1, no redirect: out_valid<=0, fetch_count<=fetch_count+1, state<=FETCH.
- DRAIN, out_ready=0: hold all outputs stable.
- DRAIN with redirect_valid: out_valid<=0, pc<=redirect_pc, state<=FETCH, fetch_count unchanged. Redirect overrides a simultaneous out_ready; decode must ignore a transfer in a redirect cycle.
- pc+4 wraps modulo 2^ADDR_WIDTH. fetch_count wraps modulo 2^32.
- imem_ack is ignored in IDLE and DRAIN.
- rst=1 in any state, including mid-transaction in FETCH or KILL, applies the reset values on that edge. The memory must discard an outstanding request on the same reset.

## Timing
- While imem_req=1, imem_addr is stable until and including the ack cycle.
- Zero-wait memory (ack in first request cycle) gives FETCH -> DRAIN -> FETCH, so peak throughput is one instruction per 2 cycles with out_ready held high.
- Fetch latency is measured from the first FETCH cycle to out_valid=1. It is (ack wait cycles + 1) clock cycles.
- First request after rst deasserts: the clock edge with rst=1 puts the block in IDLE. FETCH follows on the next edge with rst=0, so imem_req rises on the second cycle after rst deasserts.
- Redirect-to-request latency, measured from the redirect cycle to the first cycle where imem_req is high with the new address:
  - Redirect in DRAIN, or in FETCH with ack in the same cycle: 1 cycle.
  - Redirect in FETCH without ack: ack wait + 1 cycles.
- All outputs are registered or decoded from registered state. None depend combinationally on inputs.

## Test plan
- Reset and run, memory ack after 0 wait, out_ready=1, RESET_PC=0x100 -> addresses 0x100, 0x104, 0x108 in order; out_pc/out_instr match; fetch_count=3 after the third handshake.
- Back-pressure: out_ready=0 for 5 cycles while out_valid=1 -> out_pc/out_instr stable, imem_req=0, no new request until the out_ready cycle.
- Redirect during memory wait (3-cycle latency), redirect_pc=0x2003 issued in cycle 1 -> addr held until ack, returned word dropped; next request addr=0x2000; out_valid never asserted for the killed fetch.
- Two redirects during one KILL window (0x300 then 0x400) -> next request addr=0x400.
- Redirect together with out_valid=1 and out_ready=1 -> fetch_count unchanged, out_valid=0 next cycle, next request at redirect target.
- Wrap and mid-operation reset:
  - pc=0xFFFFFFFC fetched -> next addr=0x00000000.
  - rst asserted during KILL -> IDLE, out_valid=0, fetch_count=0, next request at RESET_PC.
